// File: rtl/res_st_wakeup_pkg.sv
// Shared types for the reservation station slice: micro-op encoding,
// operand/entry structs and defaults for the wakeup RS.

package qu_uop;
    // Opaque micro-op word carried through the RS untouched.
    typedef logic [7:0] uop_t;
endpackage

package qu_common;
    localparam int TAG_W = 6;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic             rdy;
    } src_operand_t;

    typedef struct packed {
        qu_uop::uop_t     uop;
        logic [TAG_W-1:0] dst_tag;
        src_operand_t     src1;
        src_operand_t     src2;
    } rs_entry_t;
endpackage

package res_st_wakeup_pkg;
    import qu_common::*;

    localparam int RES_ST_DEPTH_DEFAULT = 16;
    localparam int NUM_CDB_DEFAULT      = 2;

    // An entry may issue once both of its operands hold their values.
    function automatic logic entry_ready(input rs_entry_t e);
        return e.src1.rdy && e.src2.rdy;
    endfunction
endpackage

// File: rtl/res_st_wakeup_if.sv
// Dispatch, CDB, issue and occupancy signals of the wakeup RS.
//
// Handshakes (alloc_*, issue_*): a transfer happens on a rising clk edge
// where valid && ready are both 1. The producer holds valid/payload
// until the transfer; ready never depends on valid in the same cycle.
// The issue payload is an exception: it may switch to a lower-index
// ready entry while issue_ready is low, so the FU must not assume it is
// stable. Transfers in a cycle with flush=1 are discarded by both sides.

interface res_st_wakeup_if
    import qu_common::*;
#(
    parameter int RES_ST_DEPTH = 16,
    parameter int NUM_CDB      = 2
);
    localparam int IDX_W = $clog2(RES_ST_DEPTH);
    localparam int CNT_W = $clog2(RES_ST_DEPTH + 1);

    logic                           flush;
    logic                           alloc_valid;
    logic                           alloc_ready;
    rs_entry_t                      alloc_entry;
    logic [NUM_CDB-1:0]             cdb_valid;
    logic [NUM_CDB-1:0][TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB-1:0][XLEN-1:0]   cdb_data;
    logic                           issue_valid;
    logic                           issue_ready;
    rs_entry_t                      issue_entry;
    logic [IDX_W-1:0]               issue_idx;
    logic [CNT_W-1:0]               count;
    logic                           full;
    logic                           empty;

    // Dispatch / CDB / FU side.
    modport master (
        output flush, alloc_valid, alloc_entry, cdb_valid, cdb_tag, cdb_data,
               issue_ready,
        input  alloc_ready, issue_valid, issue_entry, issue_idx, count, full,
               empty
    );

    // Reservation station side.
    modport slave (
        input  flush, alloc_valid, alloc_entry, cdb_valid, cdb_tag, cdb_data,
               issue_ready,
        output alloc_ready, issue_valid, issue_entry, issue_idx, count, full,
               empty
    );
endinterface

// File: rtl/res_st_wakeup_prio_enc.sv
// Lowest-set-bit priority encoder: found flag plus index of the lowest
// asserted request bit (index 0 when nothing is requested).

module prio_enc #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(WIDTH)-1:0] idx
);
    localparam int IDX_W = $clog2(WIDTH);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/res_st_wakeup.sv
// Reservation station with internal slot allocation, CDB operand wakeup
// (including bypass onto the entry being allocated) and lowest-index
// oldest-slot-agnostic select toward one functional unit.

module res_st_wakeup
    import qu_common::*;
    import res_st_wakeup_pkg::*;
#(
    parameter int RES_ST_DEPTH = RES_ST_DEPTH_DEFAULT,
    parameter int NUM_CDB      = NUM_CDB_DEFAULT
) (
    input logic            clk,
    input logic            rst,
    res_st_wakeup_if.slave bus
);
    localparam int IDX_W = $clog2(RES_ST_DEPTH);
    localparam int CNT_W = $clog2(RES_ST_DEPTH + 1);

    logic [RES_ST_DEPTH-1:0] valid_q;
    rs_entry_t               entries_q [RES_ST_DEPTH];
    logic [CNT_W-1:0]        count_q;

    logic [RES_ST_DEPTH-1:0] free_vec;
    logic [RES_ST_DEPTH-1:0] ready_vec;
    logic                    free_found;
    logic [IDX_W-1:0]        free_idx;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic                    full_int;
    logic                    alloc_fire;
    logic                    issue_fire;
    rs_entry_t               alloc_woken;

    // Capture a broadcast result into a waiting operand. Lowest bus wins
    // if several buses carry the same tag; operands already holding a
    // value are never overwritten.
    function automatic src_operand_t cdb_wake(
        input src_operand_t                  src,
        input logic [NUM_CDB-1:0]            v,
        input logic [NUM_CDB-1:0][TAG_W-1:0] tags,
        input logic [NUM_CDB-1:0][XLEN-1:0]  data
    );
        src_operand_t res;
        logic         hit;
        res = src;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!src.rdy && !hit && v[k] && (tags[k] == src.tag)) begin
                res.rdy  = 1'b1;
                res.data = data[k];
                hit      = 1'b1;
            end
        end
        return res;
    endfunction

    // Free and ready vectors are judged on registered state only.
    always_comb begin
        free_vec  = ~valid_q;
        ready_vec = '0;
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && entry_ready(entries_q[i]);
        end
    end

    prio_enc #(.WIDTH(RES_ST_DEPTH)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    prio_enc #(.WIDTH(RES_ST_DEPTH)) u_sel_enc (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Handshake and status outputs; issue payload is zeroed when idle.
    always_comb begin
        full_int        = (count_q == CNT_W'(RES_ST_DEPTH));
        bus.full        = full_int;
        bus.empty       = (count_q == '0);
        bus.count       = count_q;
        bus.alloc_ready = !full_int;
        bus.issue_valid = sel_found;
        bus.issue_idx   = sel_found ? sel_idx : '0;
        bus.issue_entry = sel_found ? entries_q[sel_idx] : '0;
        alloc_fire      = bus.alloc_valid && !full_int && free_found;
        issue_fire      = sel_found && bus.issue_ready;
    end

    // Apply same-cycle broadcasts to the entry being written.
    always_comb begin
        alloc_woken      = bus.alloc_entry;
        alloc_woken.src1 = cdb_wake(bus.alloc_entry.src1, bus.cdb_valid,
                                    bus.cdb_tag, bus.cdb_data);
        alloc_woken.src2 = cdb_wake(bus.alloc_entry.src2, bus.cdb_valid,
                                    bus.cdb_tag, bus.cdb_data);
    end

    // Slot occupancy and count; flush wins over alloc and issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[free_idx] <= 1'b1;
            end
            if (issue_fire) begin
                valid_q[sel_idx] <= 1'b0;
            end
            case ({alloc_fire, issue_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payloads: write on allocation, otherwise snoop the CDB.
    // Payloads are meaningless while their valid bit is low, so they
    // carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RES_ST_DEPTH; i++) begin
            if (!bus.flush) begin
                if (alloc_fire && (free_idx == IDX_W'(i))) begin
                    entries_q[i] <= alloc_woken;
                end else if (valid_q[i]) begin
                    entries_q[i].src1 <= cdb_wake(entries_q[i].src1,
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
                    entries_q[i].src2 <= cdb_wake(entries_q[i].src2,
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
                end
            end
        end
    end
endmodule
